// File: rtl/vga_snapshot_ctrl.sv
// Snapshot sequencer: copies register file, instruction and data memory into the VGA debug RAM.
// Optional macro VGA_SNAP_AUTO_EN: a vblank rising edge also triggers a snapshot.
module vga_snapshot_ctrl #(
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned MEM_WORDS  = 92,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        snap_req,
  input  logic        vblank,
  output logic        snap_busy,
  output logic        snap_done,
  output logic [4:0]  reg_rd_addr,
  input  logic [31:0] reg_rd_data,
  output logic [31:0] imem_rd_addr,
  input  logic [31:0] imem_rd_data,
  output logic [31:0] dmem_rd_addr,
  input  logic [31:0] dmem_rd_data,
  output logic [4:0]  reg_mem_addr,
  output logic [31:0] reg_mem_data,
  output logic        reg_mem_enable,
  output logic [31:0] instr_mem_addr,
  output logic [31:0] instr_mem_data,
  output logic        instr_mem_enable,
  output logic [31:0] data_mem_addr,
  output logic [31:0] data_mem_data,
  output logic        data_mem_enable
);

  localparam int unsigned MaxN = (NUM_REGS > MEM_WORDS) ? NUM_REGS : MEM_WORDS;
  localparam int unsigned CW   = $clog2(MaxN + 1);

  typedef enum logic [2:0] {StIdle, StRegs, StInstr, StData, StDone} state_e;

  state_e        state;
  logic          pending;
  logic          iss_v;
  logic [CW-1:0] iss_a;
  logic          pipe_v [RD_LATENCY];
  logic [CW-1:0] pipe_a [RD_LATENCY];

  logic          start;
  logic          wr_v;
  logic [CW-1:0] wr_a;
  logic [CW-1:0] phase_last;
  logic [CW-1:0] iss_a_inc;
  logic          issue_last;
  logic          write_last;

`ifdef VGA_SNAP_AUTO_EN
  logic vblank_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vblank_q <= 1'b0;
    end else begin
      vblank_q <= vblank;
    end
  end

  assign start = snap_req | (vblank & ~vblank_q);
`else
  logic unused_vblank;
  assign unused_vblank = vblank;
  assign start         = snap_req;
`endif

  assign wr_v       = pipe_v[RD_LATENCY-1];
  assign wr_a       = pipe_a[RD_LATENCY-1];
  assign phase_last = (state == StRegs) ? CW'(NUM_REGS - 1) : CW'(MEM_WORDS - 1);
  assign iss_a_inc  = iss_a + CW'(1);
  assign issue_last = iss_v && (iss_a == phase_last);
  assign write_last = wr_v && (wr_a == phase_last);

  assign snap_busy = (state != StIdle);
  assign snap_done = (state == StDone);

  // Write port: delayed address, source data passed straight through in the write cycle.
  assign reg_mem_enable   = wr_v && (state == StRegs);
  assign instr_mem_enable = wr_v && (state == StInstr);
  assign data_mem_enable  = wr_v && (state == StData);
  assign reg_mem_addr     = reg_mem_enable   ? 5'(wr_a)  : '0;
  assign instr_mem_addr   = instr_mem_enable ? 32'(wr_a) : '0;
  assign data_mem_addr    = data_mem_enable  ? 32'(wr_a) : '0;
  assign reg_mem_data     = reg_mem_enable   ? reg_rd_data  : '0;
  assign instr_mem_data   = instr_mem_enable ? imem_rd_data : '0;
  assign data_mem_data    = data_mem_enable  ? dmem_rd_data : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= StIdle;
      pending      <= 1'b0;
      iss_v        <= 1'b0;
      iss_a        <= '0;
      reg_rd_addr  <= '0;
      imem_rd_addr <= '0;
      dmem_rd_addr <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_v[i] <= 1'b0;
        pipe_a[i] <= '0;
      end
    end else begin
      pipe_v[0] <= iss_v;
      pipe_a[0] <= iss_a;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_a[i] <= pipe_a[i-1];
      end

      unique case (state)
        StIdle: begin
          if (start || pending) begin
            state       <= StRegs;
            pending     <= 1'b0;
            iss_v       <= 1'b1;
            iss_a       <= '0;
            reg_rd_addr <= '0;
          end
        end
        StRegs, StInstr, StData: begin
          if (start) pending <= 1'b1;
          if (iss_v) begin
            if (issue_last) begin
              iss_v <= 1'b0;
            end else begin
              iss_a <= iss_a_inc;
              unique case (state)
                StRegs:  reg_rd_addr  <= 5'(iss_a_inc);
                StInstr: imem_rd_addr <= 32'(iss_a_inc);
                default: dmem_rd_addr <= 32'(iss_a_inc);
              endcase
            end
          end
          // The pipe is empty of this phase's reads once its last write retires.
          if (write_last) begin
            unique case (state)
              StRegs: begin
                state        <= StInstr;
                iss_v        <= 1'b1;
                iss_a        <= '0;
                imem_rd_addr <= '0;
              end
              StInstr: begin
                state        <= StData;
                iss_v        <= 1'b1;
                iss_a        <= '0;
                dmem_rd_addr <= '0;
              end
              default: state <= StDone;
            endcase
          end
        end
        StDone: begin
          if (start) pending <= 1'b1;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_snapshot_ctrl.sv
// Directed bench for vga_snapshot_ctrl at default parameters with registered source memories.
module tb_vga_snapshot_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        snap_req = 1'b0;
  logic        vblank = 1'b0;
  logic        snap_busy, snap_done;
  logic [4:0]  reg_rd_addr;
  logic [31:0] reg_rd_data = '0, imem_rd_data = '0, dmem_rd_data = '0;
  logic [31:0] imem_rd_addr, dmem_rd_addr;
  logic [4:0]  reg_mem_addr;
  logic [31:0] reg_mem_data, instr_mem_addr, instr_mem_data, data_mem_addr, data_mem_data;
  logic        reg_mem_enable, instr_mem_enable, data_mem_enable;

  int nchk = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  vga_snapshot_ctrl dut (
    .clk(clk), .rst_n(rst_n), .snap_req(snap_req), .vblank(vblank),
    .snap_busy(snap_busy), .snap_done(snap_done),
    .reg_rd_addr(reg_rd_addr), .reg_rd_data(reg_rd_data),
    .imem_rd_addr(imem_rd_addr), .imem_rd_data(imem_rd_data),
    .dmem_rd_addr(dmem_rd_addr), .dmem_rd_data(dmem_rd_data),
    .reg_mem_addr(reg_mem_addr), .reg_mem_data(reg_mem_data), .reg_mem_enable(reg_mem_enable),
    .instr_mem_addr(instr_mem_addr), .instr_mem_data(instr_mem_data),
    .instr_mem_enable(instr_mem_enable),
    .data_mem_addr(data_mem_addr), .data_mem_data(data_mem_data),
    .data_mem_enable(data_mem_enable)
  );

  // Source memories with one cycle of read latency; contents are a function of address.
  always @(posedge clk) begin
    reg_rd_data  <= 32'h100 + 32'(reg_rd_addr);
    imem_rd_data <= 32'hA000_0000 + imem_rd_addr;
    dmem_rd_data <= 32'hD000_0000 + dmem_rd_addr;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Scoreboard: per-snapshot write counters, checked in order, latched at snap_done.
  int nreg = 0, nins = 0, ndat = 0, busy_len = 0;
  int last_reg = 0, last_ins = 0, last_dat = 0, last_busy = 0, done_total = 0;

  always @(negedge clk) begin
    check("en_onehot0", 32'(reg_mem_enable) + 32'(instr_mem_enable) + 32'(data_mem_enable)
          <= 1 ? 32'd1 : 32'd0, 32'd1);
    if (!snap_busy || snap_done) begin
      check("en_idle_done", {29'd0, reg_mem_enable, instr_mem_enable, data_mem_enable}, 32'd0);
    end
    if (!snap_busy) begin
      nreg = 0; nins = 0; ndat = 0; busy_len = 0;
    end else begin
      busy_len++;
      if (reg_mem_enable) begin
        check("reg_addr", 32'(reg_mem_addr), 32'(nreg));
        check("reg_data", reg_mem_data, 32'h100 + 32'(nreg));
        nreg++;
      end
      if (instr_mem_enable) begin
        check("ins_order", 32'(nreg), 32'd32);
        check("ins_addr", instr_mem_addr, 32'(nins));
        check("ins_data", instr_mem_data, 32'hA000_0000 + 32'(nins));
        nins++;
      end
      if (data_mem_enable) begin
        check("dat_order", 32'(nins), 32'd92);
        check("dat_addr", data_mem_addr, 32'(ndat));
        check("dat_data", data_mem_data, 32'hD000_0000 + 32'(ndat));
        ndat++;
      end
      if (snap_done) begin
        last_reg = nreg; last_ins = nins; last_dat = ndat; last_busy = busy_len;
        done_total++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_req();
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (snap_done) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  task automatic check_full(input string tag);
    check({tag, "_nreg"}, 32'(last_reg), 32'd32);
    check({tag, "_nins"}, 32'(last_ins), 32'd92);
    check({tag, "_ndat"}, 32'(last_dat), 32'd92);
    check({tag, "_busy"}, 32'(last_busy), 32'd220);
  endtask

  function automatic logic [31:0] outs_or();
    return {31'd0, snap_busy | snap_done | reg_mem_enable | instr_mem_enable | data_mem_enable}
         | 32'(reg_rd_addr) | imem_rd_addr | dmem_rd_addr | 32'(reg_mem_addr) | reg_mem_data
         | instr_mem_addr | instr_mem_data | data_mem_addr | data_mem_data;
  endfunction

  initial begin
    int d0;
    bit busy_seen;

    // Reset held with request activity: everything stays 0.
    for (int i = 0; i < 4; i++) begin
      snap_req = i[0];
      tick();
    end
    snap_req = 1'b0;
    check("rst_outs", outs_or(), 32'd0);
    rst_n = 1'b1;
    tick();
    tick();
    check("post_rst_busy", 32'(snap_busy), 32'd0);
    check("post_rst_outs", outs_or(), 32'd0);

    // First-write latency and full copy.
    pulse_req();
    check("c1_busy", 32'(snap_busy), 32'd1);
    check("c1_reg_en", 32'(reg_mem_enable), 32'd0);
    tick();
    check("c2_reg_en", 32'(reg_mem_enable), 32'd1);
    check("c2_reg_addr", 32'(reg_mem_addr), 32'd0);
    check("c2_reg_data", reg_mem_data, 32'h100);
    wait_done("done_1", 400);
    d0 = done_total;
    tick();
    check("done_pulse_1cyc", 32'(snap_done), 32'd0);
    check("idle_after_done", 32'(snap_busy), 32'd0);
    check_full("run1");

    // Three requests mid-INSTR merge into exactly one extra snapshot.
    tick();
    pulse_req();
    for (int i = 0; i < 200 && nins < 10; i++) tick();
    check("reached_instr", 32'(nins >= 10), 32'd1);
    for (int i = 0; i < 3; i++) begin
      pulse_req();
      tick();
    end
    wait_done("done_2", 400);
    tick();
    check("gap_idle", 32'(snap_busy), 32'd0);
    tick();
    check("restart_busy", 32'(snap_busy), 32'd1);
    wait_done("done_3", 400);
    check_full("run3");
    busy_seen = 1'b0;
    tick();
    for (int i = 0; i < 30; i++) begin
      tick();
      busy_seen |= snap_busy;
    end
    check("no_third_run", 32'(busy_seen), 32'd0);

    // Asynchronous reset mid-DATA at k=40.
    d0 = done_total;
    pulse_req();
    for (int i = 0; i < 400 && !(snap_busy && dmem_rd_addr == 32'd40); i++) tick();
    check("reached_dat40", dmem_rd_addr, 32'd40);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_outs", outs_or(), 32'd0);
    tick();
    tick();
    check("no_done_abort", 32'(done_total), 32'(d0));
    rst_n = 1'b1;
    tick();
    pulse_req();
    wait_done("done_after_rst", 400);
    tick();
    check_full("run_rst");

    // vblank edge triggers only with the auto feature.
    tick();
    vblank = 1'b1;
    busy_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      busy_seen |= snap_busy;
    end
`ifdef VGA_SNAP_AUTO_EN
    check("vblank_trig", 32'(busy_seen), 32'd1);
    wait_done("done_vblank", 400);
    tick();
    busy_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      busy_seen |= snap_busy;
    end
    check("vblank_no_retrig", 32'(busy_seen), 32'd0);
`else
    check("vblank_ignored", 32'(busy_seen), 32'd0);
`endif
    vblank = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
